// File: rtl/logic_engine_arb_if.sv
// Handshake bundle between the requester clients, the logic-engine arbiter and the response consumer.
// The slave modport is the arbiter's view; the master modport is the client/consumer view.
interface logic_engine_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_result;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, busy
    );
endinterface

// File: rtl/logic_engine_arb.sv
// Round-robin arbiter that serialises NREQ requesters onto one bitwise logic engine
// (OR / NAND / NOR / AND) and returns id-tagged results over a back-pressurable port.
module logic_engine_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_engine_arb_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_ptr_next;

    function automatic logic [WIDTH-1:0] f_engine(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = a | b;
            2'b01:   res = ~(a & b);
            2'b10:   res = ~(a | b);
            2'b11:   res = a & b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Walks from the farthest slot back to ptr so the nearest valid requester overwrites the pick.
    function automatic logic [IDW:0] f_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  ptr
    );
        logic [IDW:0] pick;
        int           sum;
        int           idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            idx = (sum >= NREQ) ? (sum - NREQ) : sum;
            if (valid[idx]) begin
                pick = {1'b1, IDW'(idx)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Winner selection and one-hot grant; grants only in IDLE and never while reset is held.
    always_comb begin
        {w_found, w_winner} = f_pick(bus.req_valid, r_ptr);
        w_grant = '0;
        if (rst_n && (r_state == ST_IDLE) && w_found) begin
            w_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
        end else begin
            w_grant = '0;
        end
        if (w_winner == IDW'(NREQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_winner + IDW'(1);
        end
    end

    // Sequencer: capture on grant, evaluate, then hold the response until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 2'b00;
            r_id         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_id     <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_a     <= bus.req_a[w_winner*WIDTH +: WIDTH];
                        r_b     <= bus.req_b[w_winner*WIDTH +: WIDTH];
                        r_op    <= bus.req_op[w_winner*2 +: 2];
                        r_id    <= w_winner;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= f_engine(r_a, r_b, r_op);
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.busy       = r_busy;
endmodule
